// File: rtl/edid_ddc_slave_if.sv
// Bus bundle for the EDID DDC slave: host EDID write port plus DDC pad signals.
// The slave modport is the DUT view; the master modport is the host/pad side.
interface edid_ddc_slave_if;
    logic [7:0] edid_addr_i;
    logic [7:0] edid_data_i;
    logic       edid_wr_i;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oen_o;
    logic       busy_o;
    logic [7:0] offset_o;

    modport slave (
        input  edid_addr_i, edid_data_i, edid_wr_i, scl_i, sda_i,
        output sda_oen_o, busy_o, offset_o
    );

    modport master (
        output edid_addr_i, edid_data_i, edid_wr_i, scl_i, sda_i,
        input  sda_oen_o, busy_o, offset_o
    );
endinterface

// File: rtl/edid_ddc_slave.sv
// DDC/I2C slave serving a 256-byte EDID image loaded by the host one byte per write.
// Reads at the configured device address; a write transaction sets the read pointer.
module edid_ddc_slave #(
    parameter logic [6:0]  g_i2c_addr    = 7'h50,
    parameter int unsigned g_glitch_taps = 3
) (
    input  logic             clk_sys_i,
    input  logic             rst_n_i,
    edid_ddc_slave_if.slave  bus
);
    localparam int unsigned FCNT_W    = 3;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(g_glitch_taps - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, OFFSET, OFFSET_ACK,
        WDATA, WDATA_ACK, TX, TX_ACK, WAIT
    } state_t;

    // Index 1 carries SCL, index 0 carries SDA through sync, filter and edge detect.
    logic [1:0]             sync1_q, sync2_q;
    logic [1:0]             filt_q, filt_d, prev_q;
    logic [1:0][FCNT_W-1:0] fcnt_q, fcnt_d;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] sr_q, sr_d;
    logic [7:0] ptr_q, ptr_d;
    logic       rw_q, rw_d;
    logic       ack_q, ack_d;
    logic       load_q, load_d;
    logic       sda_oen_q, sda_oen_d;
    logic       busy_q, busy_d;

    logic [7:0] mem [256];
    logic [7:0] rd_data_q;

    logic sda_f, scl_rise_c, scl_fall_c, start_c, stop_c;

    // Filtered level flips only after FCNT_LAST+1 consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
                fcnt_d[i] = '0;
            end else if (fcnt_q[i] == FCNT_LAST) begin
                filt_d[i] = sync2_q[i];
                fcnt_d[i] = '0;
            end else begin
                fcnt_d[i] = fcnt_q[i] + FCNT_W'(1);
            end
        end
    end

    assign sda_f      = filt_q[0];
    assign scl_rise_c =  filt_q[1] & ~prev_q[1];
    assign scl_fall_c = ~filt_q[1] &  prev_q[1];
    assign start_c    =  filt_q[1] &  prev_q[1] &  prev_q[0] & ~filt_q[0];
    assign stop_c     =  filt_q[1] &  prev_q[1] & ~prev_q[0] &  filt_q[0];

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            filt_q  <= 2'b11;
            prev_q  <= 2'b11;
            fcnt_q  <= '0;
        end else begin
            sync1_q <= {bus.scl_i, bus.sda_i};
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            prev_q  <= filt_q;
            fcnt_q  <= fcnt_d;
        end
    end

    // Write-first registered read: a same-cycle host write to the pointer wins.
    always_ff @(posedge clk_sys_i) begin
        if (bus.edid_wr_i) mem[bus.edid_addr_i] <= bus.edid_data_i;
        rd_data_q <= (bus.edid_wr_i && (bus.edid_addr_i == ptr_q)) ? bus.edid_data_i
                                                                   : mem[ptr_q];
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        ack_d     = ack_q;
        load_d    = 1'b0;
        sda_oen_d = sda_oen_q;
        busy_d    = busy_q;
        if (start_c) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oen_d = 1'b1;
        end else if (stop_c) begin
            state_d   = IDLE;
            sda_oen_d = 1'b1;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                ADDR, OFFSET, WDATA: begin
                    if (scl_rise_c) begin
                        sr_d      = {sr_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (scl_fall_c && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = '0;
                        sda_oen_d = 1'b0;
                        if (state_q == ADDR) begin
                            if (sr_q[7:1] == g_i2c_addr) begin
                                state_d = ADDR_ACK;
                                rw_d    = sr_q[0];
                                busy_d  = 1'b1;
                            end else begin
                                state_d   = WAIT;
                                sda_oen_d = 1'b1;
                                busy_d    = 1'b0;
                            end
                        end else if (state_q == OFFSET) begin
                            ptr_d   = sr_q;
                            state_d = OFFSET_ACK;
                        end else begin
                            state_d = WDATA_ACK;
                        end
                    end
                end
                ADDR_ACK, OFFSET_ACK, WDATA_ACK: begin
                    if (scl_fall_c) begin
                        sda_oen_d = 1'b1;
                        bit_cnt_d = '0;
                        if (state_q != ADDR_ACK) begin
                            state_d = WDATA;
                        end else if (rw_q) begin
                            load_d  = 1'b1;
                            state_d = TX;
                        end else begin
                            state_d = OFFSET;
                        end
                    end
                end
                TX: begin
                    // load_q marks the cycle the registered RAM byte becomes valid.
                    if (load_q) begin
                        sr_d      = rd_data_q;
                        sda_oen_d = rd_data_q[7];
                    end else if (scl_fall_c) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            sda_oen_d = 1'b1;
                            ptr_d     = ptr_q + 8'd1;
                            state_d   = TX_ACK;
                        end else begin
                            sr_d      = {sr_q[6:0], 1'b0};
                            sda_oen_d = sr_q[6];
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise_c) ack_d = sda_f;
                    if (scl_fall_c) begin
                        if (ack_q) begin
                            state_d = WAIT;
                        end else begin
                            load_d    = 1'b1;
                            bit_cnt_d = '0;
                            state_d   = TX;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sr_q      <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            ack_q     <= 1'b1;
            load_q    <= 1'b0;
            sda_oen_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            ack_q     <= ack_d;
            load_q    <= load_d;
            sda_oen_q <= sda_oen_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.sda_oen_o = sda_oen_q;
    assign bus.busy_o    = busy_q;
    assign bus.offset_o  = ptr_q;
endmodule
